// File: rtl/dac_segment_decoder.sv
// Segmented current-steering DAC front end: clips the code, splits it into
// thermometer/binary unit enables with optional DWA rotation, and sequences pdb.
//
// state     | meaning
// ST_OFF    | array powered down, pipeline and DWA pointer held clear
// ST_SETTLE | pdb asserted, current sources settling, selects forced 0
// ST_ACTIVE | selects driven from the two-stage pipeline
module dac_segment_decoder #(
    parameter int CODE_W        = 11,
    parameter int N_THERM       = 17,
    parameter int N_BIN         = 6,
    parameter int SETTLE_CYCLES = 64,
    parameter int CODE_MAX      = 1151
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [CODE_W-1:0]  code_in,
    input  logic               dwa_en,
    input  logic               red_sel,
    input  logic [1:0]         atb_sel,
    output logic               pdb_out,
    output logic [1:0]         atb_ena,
    output logic [N_THERM-1:0] therm_sel,
    output logic [N_BIN-1:0]   bin_sel,
    output logic               bin0_red_sel,
    output logic               active,
    output logic               sat
);

    localparam int M_W   = CODE_W - N_BIN;
    localparam int P_W   = $clog2(N_THERM);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [P_W-1:0]     r_ptr;
    logic [M_W-1:0]     r_s1_m;
    logic [N_BIN-1:0]   r_s1_l;
    logic               r_s1_sat;

    logic               w_run;
    logic [CODE_W-1:0]  w_clip;
    logic               w_clip_sat;
    logic [N_THERM-1:0] w_mask;
    logic [2*N_THERM-1:0] w_rot_ext;
    logic [N_THERM-1:0] w_therm;
    logic [P_W:0]       w_ptr_sum;
    logic [P_W-1:0]     w_ptr_nxt;
    logic [N_BIN-1:0]   w_bin;
    logic               w_red;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:    w_state_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: w_state_nxt = ST_ACTIVE;
                default:   w_state_nxt = ST_OFF;
            endcase
        end
    end

    assign w_run = (w_state_nxt == ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_clip_sat = (code_in > CODE_W'(CODE_MAX));
    assign w_clip     = w_clip_sat ? CODE_W'(CODE_MAX) : code_in;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_s1_m   <= '0;
            r_s1_l   <= '0;
            r_s1_sat <= 1'b0;
        end else begin
            r_s1_m   <= w_clip[CODE_W-1:N_BIN];
            r_s1_l   <= w_clip[N_BIN-1:0];
            r_s1_sat <= w_clip_sat;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_THERM; i++) begin
            w_mask[i] = (i < int'(r_s1_m));
        end
    end

    // Rotate the M-ones mask left by the pointer, wrapping modulo N_THERM.
    assign w_rot_ext = {{N_THERM{1'b0}}, w_mask} << r_ptr;
    assign w_therm   = dwa_en ? (w_rot_ext[N_THERM-1:0] | w_rot_ext[2*N_THERM-1:N_THERM])
                              : w_mask;

    assign w_ptr_sum = (P_W+1)'(r_ptr) + (P_W+1)'(r_s1_m);
    assign w_ptr_nxt = (w_ptr_sum >= (P_W+1)'(N_THERM))
                       ? P_W'(w_ptr_sum - (P_W+1)'(N_THERM))
                       : w_ptr_sum[P_W-1:0];

    assign w_bin = red_sel ? {r_s1_l[N_BIN-1:1], 1'b0} : r_s1_l;
    assign w_red = red_sel & r_s1_l[0];

    // Pointer only advances when the selection is actually switched onto the array.
    always_ff @(posedge clk) begin
        if (rst || w_state_nxt == ST_OFF || !dwa_en) begin
            r_ptr <= '0;
        end else if (w_run) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pdb_out      <= 1'b0;
            atb_ena      <= 2'b00;
            therm_sel    <= '0;
            bin_sel      <= '0;
            bin0_red_sel <= 1'b0;
            active       <= 1'b0;
            sat          <= 1'b0;
        end else begin
            pdb_out      <= (w_state_nxt != ST_OFF);
            atb_ena      <= atb_sel;
            active       <= w_run;
            therm_sel    <= w_run ? w_therm : '0;
            bin_sel      <= w_run ? w_bin : '0;
            bin0_red_sel <= w_run & w_red;
            sat          <= w_run & r_s1_sat;
        end
    end

endmodule

// File: tb/tb_dac_segment_decoder.sv
// Directed bench for dac_segment_decoder: power-up sequence, vector table through
// the pipeline, enable drop / re-enable and reset priority.
module tb_dac_segment_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] code_in;
    logic        dwa_en;
    logic        red_sel;
    logic [1:0]  atb_sel;
    logic        pdb_out;
    logic [1:0]  atb_ena;
    logic [16:0] therm_sel;
    logic [5:0]  bin_sel;
    logic        bin0_red_sel;
    logic        active;
    logic        sat;

    int n_checks = 0;
    int n_errors = 0;

    dac_segment_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .code_in      (code_in),
        .dwa_en       (dwa_en),
        .red_sel      (red_sel),
        .atb_sel      (atb_sel),
        .pdb_out      (pdb_out),
        .atb_ena      (atb_ena),
        .therm_sel    (therm_sel),
        .bin_sel      (bin_sel),
        .bin0_red_sel (bin0_red_sel),
        .active       (active),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] code;
        logic        dwa;
        logic        red;
        logic [16:0] therm;
        logic [5:0]  bin;
        logic        red_o;
        logic        sat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, " pdb"},    32'(pdb_out), 32'd0);
        check({tag, " active"}, 32'(active), 32'd0);
        check({tag, " therm"},  32'(therm_sel), 32'd0);
        check({tag, " bin"},    32'(bin_sel), 32'd0);
        check({tag, " red"},    32'(bin0_red_sel), 32'd0);
        check({tag, " sat"},    32'(sat), 32'd0);
    endtask

    // Drives enable from OFF and checks the 64-cycle settle window; code_in
    // switches to late_code before the last two SETTLE edges.
    task automatic power_up(input logic [10:0] late_code);
        enable = 1'b1;
        tick();
        check("pu pdb c1", 32'(pdb_out), 32'd1);
        check("pu active c1", 32'(active), 32'd0);
        for (int t = 2; t <= 64; t++) begin
            tick();
            if (active !== 1'b0 || therm_sel !== 17'd0 || bin_sel !== 6'd0 || pdb_out !== 1'b1) begin
                check($sformatf("settle c%0d act/therm/bin/pdb", t),
                      {active, therm_sel, bin_sel, pdb_out}, {1'b0, 17'd0, 6'd0, 1'b1});
            end
            if (t == 63) code_in = late_code;
        end
        check("settle end active", 32'(active), 32'd0);
        tick();
        check("pu active c65", 32'(active), 32'd1);
    endtask

    function automatic vec_t mk(input int code, input bit dwa, input bit red,
                                input int therm, input int bin, input bit red_o, input bit s);
        vec_t v;
        v.code  = 11'(code);
        v.dwa   = dwa;
        v.red   = red;
        v.therm = 17'(therm);
        v.bin   = 6'(bin);
        v.red_o = red_o;
        v.sat   = s;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(200,  0, 0, 'h00007, 'h08, 0, 0);
        vecs[1]  = mk(640,  1, 0, 'h003FF, 'h00, 0, 0);
        vecs[2]  = mk(640,  1, 0, 'h1FC07, 'h00, 0, 0);
        vecs[3]  = mk(640,  1, 0, 'h01FF8, 'h00, 0, 0);
        vecs[4]  = mk(0,    1, 0, 'h00000, 'h00, 0, 0);
        vecs[5]  = mk(100,  1, 0, 'h02000, 'h24, 0, 0);
        vecs[6]  = mk(2047, 1, 0, 'h1FFFF, 'h3F, 0, 1);
        vecs[7]  = mk(1151, 1, 0, 'h1FFFF, 'h3F, 0, 0);
        vecs[8]  = mk(130,  1, 0, 'h0C000, 'h02, 0, 0);
        vecs[9]  = mk(192,  1, 0, 'h10003, 'h00, 0, 0);
        vecs[10] = mk(64,   0, 0, 'h00001, 'h00, 0, 0);
        vecs[11] = mk(64,   1, 0, 'h00001, 'h00, 0, 0);
        vecs[12] = mk(5,    0, 1, 'h00000, 'h04, 1, 0);
        vecs[13] = mk(5,    0, 0, 'h00000, 'h05, 0, 0);
        vecs[14] = mk(1088, 0, 0, 'h1FFFF, 'h00, 0, 0);
        vecs[15] = mk(1152, 0, 0, 'h1FFFF, 'h3F, 0, 1);
        vecs[16] = mk(63,   0, 1, 'h00000, 'h3E, 1, 0);
        vecs[17] = mk(1000, 1, 0, 'h07FFF, 'h28, 0, 0);

        rst = 1'b1; enable = 1'b0; code_in = '0; dwa_en = 1'b0; red_sel = 1'b0; atb_sel = 2'b10;
        repeat (3) tick();
        check_off("reset");
        check("reset atb", 32'(atb_ena), 32'd0);

        rst = 1'b0;
        power_up(11'd200);
        check("pu atb", 32'(atb_ena), 32'd2);
        check("first active therm", 32'(therm_sel), 32'h00007);
        check("first active bin", 32'(bin_sel), 32'h08);
        check("first active sat", 32'(sat), 32'd0);

        for (int i = 0; i <= NV; i++) begin
            if (i < NV) code_in = vecs[i].code;
            if (i > 0) begin
                dwa_en  = vecs[i-1].dwa;
                red_sel = vecs[i-1].red;
            end
            tick();
            if (i > 0) begin
                check($sformatf("v%0d therm", i-1), 32'(therm_sel), 32'(vecs[i-1].therm));
                check($sformatf("v%0d bin", i-1), 32'(bin_sel), 32'(vecs[i-1].bin));
                check($sformatf("v%0d red", i-1), 32'(bin0_red_sel), 32'(vecs[i-1].red_o));
                check($sformatf("v%0d sat", i-1), 32'(sat), 32'(vecs[i-1].sat));
                check($sformatf("v%0d active", i-1), 32'(active), 32'd1);
            end
        end

        enable = 1'b0; atb_sel = 2'b01;
        tick();
        check_off("drop");
        check("drop atb", 32'(atb_ena), 32'd1);

        code_in = 11'd0; dwa_en = 1'b1; red_sel = 1'b0;
        power_up(11'd640);
        check("reen therm0", 32'(therm_sel), 32'h003FF);
        tick();
        check("reen therm1", 32'(therm_sel), 32'h1FC07);
        tick();
        check("reen therm2", 32'(therm_sel), 32'h01FF8);

        rst = 1'b1;
        tick();
        check_off("rst wins");
        check("rst wins atb", 32'(atb_ena), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
